// File: rtl/game_tracker.sv
// Typing-game statistics tracker: phase FSM, one-second tick prescaler, word/error/time
// counters, a sequential words-per-minute divider and a 4-digit display code generator.
module game_tracker #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  state,
  input  logic        Mode,
  input  logic [6:0]  value,
  input  logic        key_valid,
  input  logic        key_correct,
  input  logic        word_done,
  output logic        finish,
  output logic [6:0]  remaining,
  output logic [6:0]  words,
  output logic [6:0]  elapsed,
  output logic [9:0]  errors,
  output logic [7:0]  wpm,
  output logic        wpm_valid,
  output logic [15:0] nums
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [1:0] ST_SELECT = 2'd0;
  localparam logic [1:0] ST_INGAME = 2'd2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} phase_t;
  phase_t r_phase, w_phase_nxt;

  logic [PW-1:0] r_prescale;
  logic [6:0]    r_remaining, r_words, r_elapsed, r_target;
  logic [9:0]    r_errors;
  logic          r_mode;
  logic [7:0]    r_wpm;
  logic          r_wpm_valid;
  logic          r_div_load, r_div_busy;
  logic [3:0]    r_div_cnt;
  logic [6:0]    r_div_rem;
  logic [12:0]   r_div_quo;

  logic          w_tick, w_time_up, w_target_hit, w_div_ge;
  logic [6:0]    w_words_nxt, w_div_rem_nxt;
  logic [7:0]    w_div_trial;
  logic [12:0]   w_div_quo_nxt, w_dividend;

  function automatic logic [11:0] bcd3(input logic [7:0] v);
    return {4'(v / 8'd100), 4'((v / 8'd10) % 8'd10), 4'(v % 8'd10)};
  endfunction

  function automatic logic [7:0] sat_wpm(input logic [12:0] q);
    return (q > 13'd255) ? 8'hFF : q[7:0];
  endfunction

  assign w_tick       = (r_phase == RUN) && (r_prescale == TICK_LAST);
  assign w_words_nxt  = (word_done && r_words != 7'd127) ? r_words + 7'd1 : r_words;
  assign w_time_up    = !r_mode && ((r_remaining == 7'd0) || (w_tick && r_remaining == 7'd1));
  assign w_target_hit = r_mode && (w_words_nxt == r_target);

  // Restoring divider step: the remainder always stays below the 7-bit divisor.
  assign w_dividend    = 13'(r_words) * 13'd60;
  assign w_div_trial   = {r_div_rem, r_div_quo[12]};
  assign w_div_ge      = (w_div_trial >= {1'b0, r_elapsed});
  assign w_div_rem_nxt = w_div_ge ? 7'(w_div_trial - {1'b0, r_elapsed}) : 7'(w_div_trial);
  assign w_div_quo_nxt = {r_div_quo[11:0], w_div_ge};

  always_comb begin
    w_phase_nxt = r_phase;
    if (state == ST_SELECT) begin
      w_phase_nxt = IDLE;
    end else begin
      case (r_phase)
        IDLE:    if (state == ST_INGAME) w_phase_nxt = RUN;
        RUN:     if (w_time_up || w_target_hit) w_phase_nxt = DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_phase <= IDLE;
    else     r_phase <= w_phase_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescale  <= '0;
      r_remaining <= '0;
      r_words     <= '0;
      r_elapsed   <= '0;
      r_target    <= '0;
      r_errors    <= '0;
      r_mode      <= 1'b0;
      r_wpm       <= '0;
      r_wpm_valid <= 1'b0;
      r_div_load  <= 1'b0;
      r_div_busy  <= 1'b0;
      r_div_cnt   <= '0;
      r_div_rem   <= '0;
      r_div_quo   <= '0;
    end else if (state == ST_SELECT) begin
      r_prescale  <= '0;
      r_remaining <= '0;
      r_words     <= '0;
      r_elapsed   <= '0;
      r_errors    <= '0;
      r_wpm       <= '0;
      r_wpm_valid <= 1'b0;
      r_div_load  <= 1'b0;
      r_div_busy  <= 1'b0;
    end else begin
      r_div_load <= 1'b0;
      case (r_phase)
        IDLE: begin
          if (state == ST_INGAME) begin
            r_remaining <= Mode ? 7'd0 : value;
            r_target    <= value;
            r_mode      <= Mode;
            r_prescale  <= '0;
          end
        end
        RUN: begin
          r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
          r_words    <= w_words_nxt;
          if (key_valid && !key_correct && r_errors != 10'h3FF)
            r_errors <= r_errors + 10'd1;
          if (w_tick) begin
            if (r_elapsed != 7'd127) r_elapsed <= r_elapsed + 7'd1;
            if (!r_mode && r_remaining != 7'd0) r_remaining <= r_remaining - 7'd1;
          end
          if (w_phase_nxt == DONE) r_div_load <= 1'b1;
        end
        default: begin
          // Counters are final one cycle after entering DONE, so the divide starts then.
          if (r_div_load) begin
            if (r_elapsed == 7'd0) begin
              r_wpm       <= 8'hFF;
              r_wpm_valid <= 1'b1;
            end else begin
              r_div_quo  <= w_dividend;
              r_div_rem  <= '0;
              r_div_cnt  <= 4'd13;
              r_div_busy <= 1'b1;
            end
          end else if (r_div_busy) begin
            r_div_rem <= w_div_rem_nxt;
            r_div_quo <= w_div_quo_nxt;
            r_div_cnt <= r_div_cnt - 4'd1;
            if (r_div_cnt == 4'd1) begin
              r_div_busy  <= 1'b0;
              r_wpm_valid <= 1'b1;
              r_wpm       <= sat_wpm(w_div_quo_nxt);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    nums = 16'hCCCC;
    if (r_phase == RUN) begin
      if (r_mode) nums = {4'd11, bcd3({1'b0, r_words})};
      else        nums = {4'd13, bcd3({1'b0, r_remaining})};
    end else if (r_phase == DONE && r_wpm_valid) begin
      nums = {4'd14, bcd3(r_wpm)};
    end
  end

  assign finish    = (r_phase == DONE);
  assign remaining = r_remaining;
  assign words     = r_words;
  assign elapsed   = r_elapsed;
  assign errors    = r_errors;
  assign wpm       = r_wpm;
  assign wpm_valid = r_wpm_valid;

endmodule

// File: tb/tb_game_tracker.sv
// Bench for game_tracker with TICK_DIV=4: table of whole games with a wpm scoreboard,
// plus hand-written sequences for display, DONE freezing, clearing and reset aborts.
module tb_game_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  state;
  logic        Mode;
  logic [6:0]  value;
  logic        key_valid, key_correct, word_done;
  logic        finish, wpm_valid;
  logic [6:0]  remaining, words, elapsed;
  logic [9:0]  errors;
  logic [7:0]  wpm;
  logic [15:0] nums;

  game_tracker #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .state(state), .Mode(Mode), .value(value),
    .key_valid(key_valid), .key_correct(key_correct), .word_done(word_done),
    .finish(finish), .remaining(remaining), .words(words), .elapsed(elapsed),
    .errors(errors), .wpm(wpm), .wpm_valid(wpm_valid), .nums(nums)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode; int value; int wfirst; int wper; int nwords; int nwrong;
    int exp_done; int exp_words; int exp_elapsed; int exp_remaining; int exp_errors;
    int exp_wpm; logic [15:0] exp_nums;
  } vec_t;

  vec_t vecs[7];
  vec_t sb[$];
  vec_t sb_e;
  int n_vec = 0;
  int n_miss = 0;
  logic prev_valid = 1'b0;
  logic prev_fin = 1'b0;
  int fin_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard: compare wpm result and display when wpm_valid rises.
  always @(negedge clk) begin
    if (finish && !prev_fin) fin_cnt = 0;
    else if (finish) fin_cnt++;
    if (wpm_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_wpm_valid", 1, 0);
      end else begin
        sb_e = sb.pop_front();
        check("wpm", int'(wpm), sb_e.exp_wpm);
        check("nums_done", int'(nums), int'(sb_e.exp_nums));
        check("wpm_latency_le16", int'(fin_cnt <= 16), 1);
      end
    end
    prev_valid = wpm_valid;
    prev_fin   = finish;
  end

  task automatic clear_inputs();
    key_valid = 1'b0; key_correct = 1'b0; word_done = 1'b0;
  endtask

  task automatic do_select();
    @(negedge clk);
    clear_inputs();
    state = 2'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_game(input vec_t v);
    int k;
    int w;
    do_select();
    sb.push_back(v);
    Mode = v.mode[0]; value = 7'(v.value); state = 2'd2;
    k = 0;
    while (k < 3000) begin
      @(negedge clk);
      clear_inputs();
      if (finish) break;
      k++;
      if (v.nwords > 0 && k >= v.wfirst && (k - v.wfirst) % v.wper == 0) begin
        w = (k - v.wfirst) / v.wper;
        word_done = (w < v.nwords);
      end
      key_valid   = (k <= 2 * v.nwrong);
      key_correct = (k % 2 == 0);
    end
    check("done_edge", k, v.exp_done);
    check("finish", int'(finish), 1);
    check("words", int'(words), v.exp_words);
    check("elapsed", int'(elapsed), v.exp_elapsed);
    check("remaining", int'(remaining), v.exp_remaining);
    check("errors", int'(errors), v.exp_errors);
    state = 2'd3;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("sb_wpm_valid_timeout", 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; state = 2'd0; Mode = 1'b0; value = 7'd0;
    clear_inputs();
    #1;
    check("rst_finish", int'(finish), 0);
    check("rst_nums", int'(nums), 16'hCCCC);
    check("rst_wpm_valid", int'(wpm_valid), 0);
    check("rst_counters", int'(words) + int'(elapsed) + int'(errors) + int'(remaining) + int'(wpm), 0);
    @(negedge clk); rst = 1'b0;

    //          mode val wfst wper nw  nwrong done wrd  ela rem  err   wpm  nums
    vecs[0] = '{0,   3,   0,   1,   0,  0,     12,  0,   3,  0,   0,    0,   16'hE000};
    vecs[1] = '{1,   2,   5,   4,   2,  0,     9,   2,   2,  0,   0,    60,  16'hE060};
    vecs[2] = '{0,   30,  1,   4,   5,  0,     120, 5,   30, 0,   0,    10,  16'hE010};
    vecs[3] = '{1,   1,   2100,1,   1,  1030,  2100,1,   127,0,   1023, 0,   16'hE000};
    vecs[4] = '{0,   2,   8,   1,   1,  0,     8,   1,   2,  0,   0,    30,  16'hE030};
    vecs[5] = '{0,   0,   0,   1,   0,  0,     1,   0,   0,  0,   0,    255, 16'hE255};
    vecs[6] = '{0,   5,   2,   3,   20, 7,     20,  7,   5,  0,   7,    84,  16'hE084};
    for (int i = 0; i < 7; i++) run_game(vecs[i]);

    // Still DONE from the last game: keys and words must be ignored.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      key_valid = 1'b1; key_correct = 1'b0; word_done = 1'b1;
    end
    @(negedge clk); clear_inputs();
    check("done_errors_frozen", int'(errors), 7);
    check("done_words_frozen", int'(words), 7);
    check("done_finish_held", int'(finish), 1);

    state = 2'd0;
    @(negedge clk);
    check("sel_finish", int'(finish), 0);
    check("sel_clear", int'(words) + int'(elapsed) + int'(errors) + int'(remaining) + int'(wpm), 0);
    check("sel_wpm_valid", int'(wpm_valid), 0);
    check("sel_nums", int'(nums), 16'hCCCC);

    // Timed-game display during RUN, then reset mid-game.
    do_select();
    Mode = 1'b0; value = 7'd3; state = 2'd2;
    @(negedge clk);
    check("run_m0_nums_start", int'(nums), 16'hD003);
    repeat (4) @(negedge clk);
    check("run_m0_remaining", int'(remaining), 2);
    check("run_m0_nums_tick", int'(nums), 16'hD002);
    rst = 1'b1; state = 2'd0; #1;
    check("rst_run_nums", int'(nums), 16'hCCCC);
    check("rst_run_remaining", int'(remaining), 0);
    @(negedge clk); rst = 1'b0;

    // Word-count display during RUN, then reset mid-game.
    do_select();
    Mode = 1'b1; value = 7'd3; state = 2'd2;
    @(negedge clk);
    check("run_m1_nums_start", int'(nums), 16'hB000);
    word_done = 1'b1; key_valid = 1'b1; key_correct = 1'b0;
    @(negedge clk); clear_inputs();
    check("run_m1_words", int'(words), 1);
    check("run_m1_errors", int'(errors), 1);
    check("run_m1_nums", int'(nums), 16'hB001);
    repeat (4) @(negedge clk);
    check("run_m1_elapsed", int'(elapsed), 1);
    rst = 1'b1; state = 2'd0; #1;
    check("rst_mid_finish", int'(finish), 0);
    check("rst_mid_counters", int'(words) + int'(elapsed) + int'(errors), 0);
    check("rst_mid_nums", int'(nums), 16'hCCCC);
    @(negedge clk); rst = 1'b0;

    // Reset during the divide: the result must never appear.
    do_select();
    Mode = 1'b0; value = 7'd1; state = 2'd2;
    for (int i = 0; i < 20 && !finish; i++) @(negedge clk);
    check("div_abort_finish_seen", int'(finish), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1; state = 2'd0; #1;
    check("div_abort_finish", int'(finish), 0);
    check("div_abort_wpm_valid", int'(wpm_valid), 0);
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    check("div_abort_no_result", int'(wpm_valid), 0);
    check("div_abort_nums", int'(nums), 16'hCCCC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/game_tracker.md
GAME_TRACKER -- requirements
Module: game_tracker

Interface
REQ-001 Parameter TICK_DIV, default 100_000_000, clk cycles per one-second game tick.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 state  input  2  game phase from control: 0 SELECT, 1 COUNTDOWN, 2 INGAME, 3 FINISH.
REQ-005 Mode  input  1  0 = timed game, 1 = word-count game.
REQ-006 value  input  7  time limit in seconds (Mode=0) or word target (Mode=1).
REQ-007 key_valid  input  1  one-cycle pulse per typed key.
REQ-008 key_correct  input  1  qualifies key_valid; 1 = correct key.
REQ-009 word_done  input  1  one-cycle pulse per completed word.
REQ-010 finish  output  1  game over, level, to control.
REQ-011 remaining  output  7  seconds left (Mode=0).
REQ-012 words  output  7  completed words.
REQ-013 elapsed  output  7  seconds elapsed.
REQ-014 errors  output  10  incorrect keystrokes.
REQ-015 wpm  output  8  words per minute result.
REQ-016 wpm_valid  output  1  wpm is final.
REQ-017 nums  output  16  four 4-bit display digit codes, [3:0] least significant.

Function
REQ-018 Internal phase FSM IDLE, RUN, DONE shall be registered; finish SHALL equal (phase==DONE).
REQ-019 state==SELECT in any phase SHALL force IDLE next edge and clear words, elapsed, errors, wpm, wpm_valid, prescaler; remaining SHALL load 0.
REQ-020 IDLE -> RUN on the first edge with state==INGAME; same edge SHALL load remaining=value (Mode=0) and latch target=value, prescaler=0.
REQ-021 RUN: prescaler counts 0..TICK_DIV-1 and wraps; wrap cycle is a tick.
REQ-022 Each tick SHALL increment elapsed, saturating at 127; Mode=0 SHALL also decrement remaining.
REQ-023 Mode=0: edge where remaining goes 1->0 SHALL also move phase to DONE; value=0 SHALL go DONE on the first RUN edge.
REQ-024 RUN: word_done SHALL increment words (saturate 127); Mode=1 edge making words==target SHALL move phase to DONE.
REQ-025 RUN: key_valid&~key_correct SHALL increment errors, saturating at 1023; other keys ignored.
REQ-026 Simultaneous word_done and final tick SHALL count the word before entering DONE.
REQ-027 DONE: all counters frozen; inputs key_valid, word_done ignored; stays DONE until state==SELECT.
REQ-028 Entry to DONE SHALL start a sequential restoring divider: dividend words*60 (13 bits), divisor elapsed.
REQ-029 wpm SHALL be the floor quotient saturated to 255; elapsed==0 SHALL give wpm=255.
REQ-030 wpm_valid SHALL rise within 16 clk cycles of finish rising and hold until cleared by REQ-019.
REQ-031 nums in RUN: Mode=0 shows remaining as 3 BCD digits, [15:12]=13; Mode=1 shows words as 3 BCD digits, [15:12]=11.
REQ-032 nums in DONE with wpm_valid: wpm as 3 BCD digits, [15:12]=14; in all other cases every digit = 12 (blank).
REQ-033 state values COUNTDOWN or FINISH SHALL not change phase except per REQ-020/REQ-019.

Reset
REQ-034 rst SHALL immediately set phase IDLE, all counters, wpm, wpm_valid, finish to 0, nums to 16'hCCCC.
REQ-035 rst mid-game or mid-divide SHALL abort with no residual state; the divider SHALL not complete after rst.

Verification (TICK_DIV=4)
REQ-036 Mode=0, value=3, state=INGAME -> remaining 3,2,1,0 every 4 cycles; finish high after third tick; elapsed=3.
REQ-037 Mode=1, value=2, word_done pulses at cycles 5 and 9 -> words=2, finish high next cycle, elapsed=2.
REQ-038 Done with words=5, elapsed=30 -> wpm=10, wpm_valid within 16 cycles, nums=16'hE010.
REQ-039 1030 wrong keys in RUN -> errors=1023; keys in DONE -> no change.
REQ-040 word_done on the final-tick cycle, Mode=0 -> word counted, finish asserted.
REQ-041 state=SELECT while DONE, then rst mid-RUN -> finish=0, all counters=0, nums=16'hCCCC.
